// File: rtl/apb_node_timeout.sv
// apb_node_timeout: APB3 single-master to NB_SLAVE-slave bridge with a runtime
// address map, registered downstream phase, decode-error response and slave timeout.
module apb_node_timeout #(
  parameter int NB_SLAVE       = 11,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [ADDR_WIDTH-1:0]          s_paddr_i,
  input  logic [DATA_WIDTH-1:0]          s_pwdata_i,
  input  logic                           s_pwrite_i,
  input  logic                           s_psel_i,
  input  logic                           s_penable_i,
  output logic [DATA_WIDTH-1:0]          s_prdata_o,
  output logic                           s_pready_o,
  output logic                           s_pslverr_o,
  output logic [ADDR_WIDTH-1:0]          m_paddr_o,
  output logic [DATA_WIDTH-1:0]          m_pwdata_o,
  output logic                           m_pwrite_o,
  output logic                           m_penable_o,
  output logic [NB_SLAVE-1:0]            m_psel_o,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0] m_prdata_i,
  input  logic [NB_SLAVE-1:0]            m_pready_i,
  input  logic [NB_SLAVE-1:0]            m_pslverr_i,
  output logic                           decerr_o,
  output logic                           timeout_o,
  output logic [ADDR_WIDTH-1:0]          err_addr_o
);

  localparam int IDX_W = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    M_SETUP,
    M_ACCESS,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   decerr_q, decerr_d;
  logic                   timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   sel_ready;
  logic                   sel_err;
  logic                   active;

  // Ascending scan with a found flag so the lowest-indexed overlapping region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NB_SLAVE; k++) begin
      if (!hit &&
          (start_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] <= s_paddr_i) &&
          (s_paddr_i <= end_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  assign sel_rdata = m_prdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ready = m_pready_i[idx_q];
  assign sel_err   = m_pslverr_i[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    decerr_d   = 1'b0;
    timeout_d  = 1'b0;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: begin
        if (s_psel_i && !s_penable_i) begin
          addr_d  = s_paddr_i;
          wdata_d = s_pwdata_i;
          write_d = s_pwrite_i;
          idx_d   = hit_idx;
          rdata_d = '0;
          err_d   = 1'b0;
          if (hit) begin
            state_d = M_SETUP;
          end else begin
            state_d    = RESP;
            err_d      = 1'b1;
            decerr_d   = 1'b1;
            err_addr_d = s_paddr_i;
          end
        end
      end
      M_SETUP: begin
        cnt_d   = '0;
        state_d = M_ACCESS;
      end
      M_ACCESS: begin
        if (sel_ready) begin
          rdata_d = (write_q || sel_err) ? '0 : sel_rdata;
          err_d   = sel_err;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          rdata_d    = '0;
          err_d      = 1'b1;
          timeout_d  = 1'b1;
          err_addr_d = addr_q;
          state_d    = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      decerr_q   <= 1'b0;
      timeout_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      decerr_q   <= decerr_d;
      timeout_q  <= timeout_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Select/enable decode from the state register so reset drops them at once.
  assign active = (state_q == M_SETUP) || (state_q == M_ACCESS);

  always_comb begin
    m_psel_o = '0;
    for (int unsigned k = 0; k < NB_SLAVE; k++) begin
      m_psel_o[k] = active && (idx_q == IDX_W'(k));
    end
  end

  assign m_penable_o = (state_q == M_ACCESS);
  assign m_paddr_o   = addr_q;
  assign m_pwdata_o  = wdata_q;
  assign m_pwrite_o  = write_q;

  assign s_pready_o  = (state_q == RESP);
  assign s_prdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign s_pslverr_o = (state_q == RESP) && err_q;

  assign decerr_o    = decerr_q;
  assign timeout_o   = timeout_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_apb_node_timeout.sv
// Table-driven bench for apb_node_timeout with a behavioural slave array and
// a scoreboard of expected upstream responses.
module tb_apb_node_timeout;

  localparam int NB = 11;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NB*AW-1:0]  start_addr_i, end_addr_i;
  logic [AW-1:0]     s_paddr_i;
  logic [DW-1:0]     s_pwdata_i;
  logic              s_pwrite_i, s_psel_i, s_penable_i;
  logic [DW-1:0]     s_prdata_o;
  logic              s_pready_o, s_pslverr_o;
  logic [AW-1:0]     m_paddr_o;
  logic [DW-1:0]     m_pwdata_o;
  logic              m_pwrite_o, m_penable_o;
  logic [NB-1:0]     m_psel_o;
  logic [NB*DW-1:0]  m_prdata_i;
  logic [NB-1:0]     m_pready_i, m_pslverr_i;
  logic              decerr_o, timeout_o;
  logic [AW-1:0]     err_addr_o;

  apb_node_timeout #(
    .NB_SLAVE      (NB),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .s_paddr_i   (s_paddr_i),
    .s_pwdata_i  (s_pwdata_i),
    .s_pwrite_i  (s_pwrite_i),
    .s_psel_i    (s_psel_i),
    .s_penable_i (s_penable_i),
    .s_prdata_o  (s_prdata_o),
    .s_pready_o  (s_pready_o),
    .s_pslverr_o (s_pslverr_o),
    .m_paddr_o   (m_paddr_o),
    .m_pwdata_o  (m_pwdata_o),
    .m_pwrite_o  (m_pwrite_o),
    .m_penable_o (m_penable_o),
    .m_psel_o    (m_psel_o),
    .m_prdata_i  (m_prdata_i),
    .m_pready_i  (m_pready_i),
    .m_pslverr_i (m_pslverr_i),
    .decerr_o    (decerr_o),
    .timeout_o   (timeout_o),
    .err_addr_o  (err_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Behavioural slaves: the target answers after wait_cfg access cycles (-1 = never).
  int           tgt_cfg  = -1;
  int           wait_cfg = 0;
  logic [DW-1:0] rd_val  = '0;
  logic          serr_cfg = 1'b0;
  int           acc_cnt  = 0;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) acc_cnt <= 0;
    else if (m_penable_o) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    m_prdata_i  = '0;
    m_pready_i  = '0;
    m_pslverr_i = '0;
    for (int k = 0; k < NB; k++) begin
      m_prdata_i[k*DW +: DW] = (k == tgt_cfg) ? rd_val : (32'hBAD0_0000 | 32'(k));
      m_pready_i[k]  = m_psel_o[k] & m_penable_o & (wait_cfg >= 0) & (acc_cnt == wait_cfg);
      m_pslverr_i[k] = m_psel_o[k] & serr_cfg;
    end
  end

  // Downstream monitor: selects seen, enable cycles, and the broadcast phase.
  logic [NB-1:0] sel_seen = '0;
  int            pen_cnt  = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic          cap_wr = 1'b0;

  always @(negedge clk) begin
    sel_seen = sel_seen | m_psel_o;
    if (m_penable_o) pen_cnt = pen_cnt + 1;
    if (m_psel_o != '0) begin
      cap_addr  = m_paddr_o;
      cap_wdata = m_pwdata_o;
      cap_wr    = m_pwrite_o;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    int            tgt;
    int            wt;
    logic [DW-1:0] rd;
    logic          serr;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_dec;
    logic          exp_to;
    logic [NB-1:0] exp_sel;
    int            exp_pen;
  } vec_t;

  typedef struct {
    int            t0;
    int            lat;
    logic [DW-1:0] rdata;
    logic          err;
    logic          dec;
    logic          to;
    logic [NB-1:0] sel;
    int            pen;
    logic [AW-1:0] eaddr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[12];
  logic [AW-1:0] last_err = '0;

  function automatic vec_t mk(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic wr, input int tgt, input int wt,
                              input logic [DW-1:0] rd, input logic serr, input int lat,
                              input logic [DW-1:0] erd, input logic eerr, input logic dec,
                              input logic to, input logic [NB-1:0] sel, input int pen);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wr = wr; v.tgt = tgt; v.wt = wt; v.rd = rd;
    v.serr = serr; v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr;
    v.exp_dec = dec; v.exp_to = to; v.exp_sel = sel; v.exp_pen = pen;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " m_psel"},     64'(m_psel_o),    64'd0);
    chk({tag, " m_penable"},  64'(m_penable_o), 64'd0);
    chk({tag, " m_paddr"},    64'(m_paddr_o),   64'd0);
    chk({tag, " m_pwdata"},   64'(m_pwdata_o),  64'd0);
    chk({tag, " m_pwrite"},   64'(m_pwrite_o),  64'd0);
    chk({tag, " s_pready"},   64'(s_pready_o),  64'd0);
    chk({tag, " s_prdata"},   64'(s_prdata_o),  64'd0);
    chk({tag, " s_pslverr"},  64'(s_pslverr_o), 64'd0);
    chk({tag, " decerr"},     64'(decerr_o),    64'd0);
    chk({tag, " timeout"},    64'(timeout_o),   64'd0);
    chk({tag, " err_addr"},   64'(err_addr_o),  64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    exp_t r;
    bit   got;
    @(negedge clk);
    chk($sformatf("v%0d idle_pready", id),  64'(s_pready_o), 64'd0);
    chk($sformatf("v%0d idle_decerr", id),  64'(decerr_o),   64'd0);
    chk($sformatf("v%0d idle_timeout", id), 64'(timeout_o),  64'd0);
    tgt_cfg  = v.tgt;
    wait_cfg = v.wt;
    rd_val   = v.rd;
    serr_cfg = v.serr;
    s_paddr_i   = v.addr;
    s_pwdata_i  = v.wdata;
    s_pwrite_i  = v.wr;
    s_psel_i    = 1'b1;
    s_penable_i = 1'b0;
    sel_seen = '0;
    pen_cnt  = 0;
    if (v.exp_dec || v.exp_to) last_err = v.addr;
    e.t0 = cyc; e.lat = v.exp_lat; e.rdata = v.exp_rdata; e.err = v.exp_err;
    e.dec = v.exp_dec; e.to = v.exp_to; e.sel = v.exp_sel; e.pen = v.exp_pen;
    e.eaddr = last_err; e.addr = v.addr; e.wdata = v.wdata; e.wr = v.wr;
    sb.push_back(e);
    @(negedge clk);
    s_penable_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_pready_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    r = sb.pop_front();
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL v%0d pready_wait: no s_pready_o within 20 cycles, required after %0d", id, r.lat);
    end else begin
      chk($sformatf("v%0d latency", id),  64'(cyc - r.t0),  64'(r.lat));
      chk($sformatf("v%0d prdata", id),   64'(s_prdata_o),  64'(r.rdata));
      chk($sformatf("v%0d pslverr", id),  64'(s_pslverr_o), 64'(r.err));
      chk($sformatf("v%0d decerr", id),   64'(decerr_o),    64'(r.dec));
      chk($sformatf("v%0d timeout", id),  64'(timeout_o),   64'(r.to));
      chk($sformatf("v%0d err_addr", id), 64'(err_addr_o),  64'(r.eaddr));
      chk($sformatf("v%0d psel_seen", id), 64'(sel_seen),   64'(r.sel));
      chk($sformatf("v%0d pen_cycles", id), 64'(pen_cnt),   64'(r.pen));
      if (r.sel != '0) begin
        chk($sformatf("v%0d m_paddr", id),  64'(cap_addr),  64'(r.addr));
        chk($sformatf("v%0d m_pwdata", id), 64'(cap_wdata), 64'(r.wdata));
        chk($sformatf("v%0d m_pwrite", id), 64'(cap_wr),    64'(r.wr));
      end
    end
    s_psel_i    = 1'b0;
    s_penable_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    s_paddr_i = '0; s_pwdata_i = '0; s_pwrite_i = 1'b0; s_psel_i = 1'b0; s_penable_i = 1'b0;
    // Unused slaves get start > end so they never decode.
    for (int k = 0; k < NB; k++) begin
      start_addr_i[k*AW +: AW] = 32'hFFFF_FFFF;
      end_addr_i[k*AW +: AW]   = 32'h0000_0000;
    end
    start_addr_i[0*AW +: AW]  = 32'h1A00_0000; end_addr_i[0*AW +: AW]  = 32'h1A00_0FFF;
    start_addr_i[1*AW +: AW]  = 32'h1A10_0000; end_addr_i[1*AW +: AW]  = 32'h1A10_0FFF;
    start_addr_i[2*AW +: AW]  = 32'h1A10_2000; end_addr_i[2*AW +: AW]  = 32'h1A10_2FFF;
    start_addr_i[3*AW +: AW]  = 32'h2000_0000; end_addr_i[3*AW +: AW]  = 32'h1000_0000;
    start_addr_i[4*AW +: AW]  = 32'h3000_0000; end_addr_i[4*AW +: AW]  = 32'h3000_00FF;
    start_addr_i[5*AW +: AW]  = 32'h1A10_1000; end_addr_i[5*AW +: AW]  = 32'h1A10_3FFF;
    start_addr_i[10*AW +: AW] = 32'h1A20_0000; end_addr_i[10*AW +: AW] = 32'h1A20_FFFF;

    //            addr          wdata         wr tgt wt  slave rd      serr lat exp rdata    err dec to  sel              pen
    vecs[0]  = mk(32'h1A10_0004, 32'hA5A5_0001, 1, 1,  0, 32'h1111_1111, 0, 3, 32'h0,         0, 0, 0, 11'b000_0000_0010, 1);
    vecs[1]  = mk(32'h1A20_0010, 32'h0,         0, 10, 3, 32'h1234_5678, 0, 6, 32'h1234_5678, 0, 0, 0, 11'b100_0000_0000, 4);
    vecs[2]  = mk(32'h0000_0000, 32'h0,         0, -1, 0, 32'h0,         0, 1, 32'h0,         1, 1, 0, 11'b000_0000_0000, 0);
    vecs[3]  = mk(32'h1A10_2000, 32'h0,         0, 2,  1, 32'hCAFE_0002, 0, 4, 32'hCAFE_0002, 0, 0, 0, 11'b000_0000_0100, 2);
    vecs[4]  = mk(32'h1A00_0040, 32'h0,         0, 0, -1, 32'h5555_5555, 0, 6, 32'h0,         1, 0, 1, 11'b000_0000_0001, 4);
    vecs[5]  = mk(32'h1A00_0044, 32'h0BAD_BEEF, 1, 0,  3, 32'h7777_7777, 0, 6, 32'h0,         0, 0, 0, 11'b000_0000_0001, 4);
    vecs[6]  = mk(32'h3000_0080, 32'h0,         0, 4,  2, 32'h4444_4444, 1, 5, 32'h0,         1, 0, 0, 11'b000_0001_0000, 3);
    vecs[7]  = mk(32'h1800_0000, 32'h0,         0, -1, 0, 32'h0,         0, 1, 32'h0,         1, 1, 0, 11'b000_0000_0000, 0);
    vecs[8]  = mk(32'h1A10_0FFF, 32'h0,         0, 1,  0, 32'h0BAD_F00D, 0, 3, 32'h0BAD_F00D, 0, 0, 0, 11'b000_0000_0010, 1);
    vecs[9]  = mk(32'h1A10_1000, 32'h0000_5A5A, 1, 5,  0, 32'h9999_9999, 0, 3, 32'h0,         0, 0, 0, 11'b000_0010_0000, 1);
    vecs[10] = mk(32'hFFFF_FFFF, 32'h0,         0, -1, 0, 32'h0,         0, 1, 32'h0,         1, 1, 0, 11'b000_0000_0000, 0);
    vecs[11] = mk(32'h1A20_0000, 32'h0,         0, 10, 0, 32'hFEDC_BA98, 0, 3, 32'hFEDC_BA98, 0, 0, 0, 11'b100_0000_0000, 1);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset asserted while slave 10 is stalled in the access phase.
    @(negedge clk);
    tgt_cfg = 10; wait_cfg = -1; rd_val = 32'h0; serr_cfg = 1'b0;
    s_paddr_i = 32'h1A20_0100; s_pwdata_i = 32'h0; s_pwrite_i = 1'b0;
    s_psel_i = 1'b1; s_penable_i = 1'b0;
    @(negedge clk);
    s_penable_i = 1'b1;
    @(negedge clk);
    chk("rstmid pre m_penable", 64'(m_penable_o), 64'd1);
    chk("rstmid pre m_psel",    64'(m_psel_o),    64'(11'b100_0000_0000));
    #1 rst_i = 1'b1;
    #1 chk_zero("rstmid");
    @(negedge clk);
    s_psel_i = 1'b0; s_penable_i = 1'b0;
    rst_i = 1'b0;
    last_err = '0;
    run_vec(vecs[0], 100);
    run_vec(vecs[4], 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
